omsp_spm_ctrl_seq: RTL

- Next-generation Sancus protected-module (SPM) controller with parametrised slot count and an internal registered layout table.
- Replaces the combinational first-free-slot update with a sequential allocate/destroy engine:
  - layout validation
  - per-slot overlap scan
  - ID assignment
  - busy/done handshake
- Sits beside the execution unit. It snoops pc and the EU memory bus, and flags memory-access and entry-point violations with a registered, latched report.

---
 rtl/omsp_spm_ctrl_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/omsp_spm_ctrl_seq.sv
// Sancus protected-module controller: sequential allocate/destroy engine over a
// registered slot table, plus per-cycle memory-access and entry-point violation checks.
module omsp_spm_ctrl_seq #(
    parameter int NB_SPMS  = 4,
    parameter int ID_WIDTH = 16,
    parameter int AW       = 16
) (
    input  logic                           mclk,
    input  logic                           puc_rst,
    input  logic [AW-1:0]                  pc,
    input  logic [AW-1:0]                  eu_mab,
    input  logic                           eu_mb_en,
    input  logic [1:0]                     eu_mb_wr,
    input  logic                           update_spm,
    input  logic                           enable_spm,
    input  logic [AW-1:0]                  r12,
    input  logic [AW-1:0]                  r13,
    input  logic [AW-1:0]                  r14,
    input  logic [AW-1:0]                  r15,
    output logic                           busy,
    output logic                           done,
    output logic                           result_ok,
    output logic [ID_WIDTH-1:0]            spm_id,
    output logic [$clog2(NB_SPMS+1)-1:0]   nb_enabled,
    output logic                           violation,
    output logic [AW-1:0]                  violation_addr,
    output logic [AW-1:0]                  violation_pc
);
    localparam int IW = (NB_SPMS > 1) ? $clog2(NB_SPMS) : 1;
    localparam int CW = $clog2(NB_SPMS + 1);
    localparam logic [ID_WIDTH-1:0] ID_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

    function automatic logic f_in(input logic [AW-1:0] a, input logic [AW-1:0] s, input logic [AW-1:0] e);
        return (a >= s) && (a < e);
    endfunction

    function automatic logic f_ov(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                  input logic [AW-1:0] b0, input logic [AW-1:0] b1);
        return (a0 < b1) && (b0 < a1);
    endfunction

    state_t r_state, w_state_next;

    logic [NB_SPMS-1:0]  r_en;
    logic [AW-1:0]       r_pub_s [NB_SPMS];
    logic [AW-1:0]       r_pub_e [NB_SPMS];
    logic [AW-1:0]       r_sec_s [NB_SPMS];
    logic [AW-1:0]       r_sec_e [NB_SPMS];
    logic [ID_WIDTH-1:0] r_id    [NB_SPMS];
    logic [ID_WIDTH-1:0] r_next_id;
    logic [CW-1:0]       r_nb;

    logic [AW-1:0] r_pub_s_l, r_pub_e_l, r_sec_s_l, r_sec_e_l, r_pc_l;
    logic          r_create, r_fail, r_free_found, r_match_found, r_rej;
    logic [IW-1:0] r_idx, r_free_idx, r_match_idx;
    logic [AW-1:0] r_prev_pc;
    logic          r_violation;
    logic [AW-1:0] r_viol_addr, r_viol_pc;

    logic w_req, w_layout_bad, w_reject, w_start, w_last, w_commit_ok;
    logic w_cur_en, w_cur_ov, w_cur_hit;
    logic [NB_SPMS-1:0] w_rule_a, w_rule_b;
    logic w_unused_wr;

    // Write strobes are not needed: any enabled access to a secret section is checked.
    assign w_unused_wr = ^eu_mb_wr;

    assign w_req        = update_spm && (r_state == S_IDLE);
    assign w_layout_bad = (r12 >= r13) || (r14 >= r15) || f_ov(r12, r13, r14, r15);
    assign w_reject     = w_req && enable_spm && w_layout_bad;
    assign w_start      = w_req && !w_reject;
    assign w_last       = (r_idx == IW'(NB_SPMS - 1));
    assign w_commit_ok  = r_create ? (!r_fail && r_free_found) : r_match_found;

    assign w_cur_en  = r_en[r_idx];
    assign w_cur_ov  = f_ov(r_pub_s_l, r_pub_e_l, r_pub_s[r_idx], r_pub_e[r_idx]) ||
                       f_ov(r_pub_s_l, r_pub_e_l, r_sec_s[r_idx], r_sec_e[r_idx]) ||
                       f_ov(r_sec_s_l, r_sec_e_l, r_pub_s[r_idx], r_pub_e[r_idx]) ||
                       f_ov(r_sec_s_l, r_sec_e_l, r_sec_s[r_idx], r_sec_e[r_idx]);
    assign w_cur_hit = f_in(r_pc_l, r_pub_s[r_idx], r_pub_e[r_idx]);

    always_ff @(posedge mclk) begin
        if (puc_rst) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_next = S_SCAN;
            S_SCAN:   if (w_last)  w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_SCAN);
        done      = r_rej || (r_state == S_COMMIT);
        result_ok = (r_state == S_COMMIT) && w_commit_ok;
        spm_id    = '0;
        if (result_ok) spm_id = r_create ? r_next_id : r_id[r_match_idx];
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_en          <= '0;
            r_next_id     <= ID_WIDTH'(1);
            r_nb          <= '0;
            r_pub_s_l     <= '0;
            r_pub_e_l     <= '0;
            r_sec_s_l     <= '0;
            r_sec_e_l     <= '0;
            r_pc_l        <= '0;
            r_create      <= 1'b0;
            r_fail        <= 1'b0;
            r_free_found  <= 1'b0;
            r_match_found <= 1'b0;
            r_rej         <= 1'b0;
            r_idx         <= '0;
            r_free_idx    <= '0;
            r_match_idx   <= '0;
            for (int i = 0; i < NB_SPMS; i++) begin
                r_pub_s[i] <= '0;
                r_pub_e[i] <= '0;
                r_sec_s[i] <= '0;
                r_sec_e[i] <= '0;
                r_id[i]    <= '0;
            end
        end else begin
            r_rej <= w_reject;
            if (w_start) begin
                r_pub_s_l     <= r12;
                r_pub_e_l     <= r13;
                r_sec_s_l     <= r14;
                r_sec_e_l     <= r15;
                r_pc_l        <= pc;
                r_create      <= enable_spm;
                r_idx         <= '0;
                r_fail        <= 1'b0;
                r_free_found  <= 1'b0;
                r_match_found <= 1'b0;
            end
            if (r_state == S_SCAN) begin
                r_idx <= r_idx + IW'(1);
                if (w_cur_en && w_cur_ov) r_fail <= 1'b1;
                if (!r_free_found && !w_cur_en) begin
                    r_free_found <= 1'b1;
                    r_free_idx   <= r_idx;
                end
                if (!r_match_found && w_cur_en && w_cur_hit) begin
                    r_match_found <= 1'b1;
                    r_match_idx   <= r_idx;
                end
            end
            if (r_state == S_COMMIT && w_commit_ok) begin
                if (r_create) begin
                    r_en[r_free_idx]    <= 1'b1;
                    r_pub_s[r_free_idx] <= r_pub_s_l;
                    r_pub_e[r_free_idx] <= r_pub_e_l;
                    r_sec_s[r_free_idx] <= r_sec_s_l;
                    r_sec_e[r_free_idx] <= r_sec_e_l;
                    r_id[r_free_idx]    <= r_next_id;
                    r_next_id <= (r_next_id == ID_MAX) ? ID_WIDTH'(1) : r_next_id + ID_WIDTH'(1);
                    r_nb      <= r_nb + CW'(1);
                end else begin
                    r_en[r_match_idx] <= 1'b0;
                    r_nb              <= r_nb - CW'(1);
                end
            end
        end
    end

    // Per-slot access rules; any slot hit raises the shared violation report.
    for (genvar gi = 0; gi < NB_SPMS; gi++) begin : g_chk
        assign w_rule_a[gi] = r_en[gi] && eu_mb_en && f_in(eu_mab, r_sec_s[gi], r_sec_e[gi]) &&
                              !f_in(pc, r_pub_s[gi], r_pub_e[gi]);
        assign w_rule_b[gi] = r_en[gi] && !f_in(r_prev_pc, r_pub_s[gi], r_pub_e[gi]) &&
                              f_in(pc, r_pub_s[gi], r_pub_e[gi]) && (pc != r_pub_s[gi]);
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_prev_pc   <= '0;
            r_violation <= 1'b0;
            r_viol_addr <= '0;
            r_viol_pc   <= '0;
        end else begin
            r_prev_pc   <= pc;
            r_violation <= (|w_rule_a) || (|w_rule_b);
            if (|w_rule_a) begin
                r_viol_addr <= eu_mab;
                r_viol_pc   <= pc;
            end else if (|w_rule_b) begin
                r_viol_addr <= pc;
                r_viol_pc   <= pc;
            end
        end
    end

    assign nb_enabled     = r_nb;
    assign violation      = r_violation;
    assign violation_addr = r_viol_addr;
    assign violation_pc   = r_viol_pc;
endmodule
